// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command-side initiator for alu_8bit. Accepts load / ALU-op commands over a
//   valid/ready pair, keeps an 8 x 8-bit register file (r0 is accumulator A)
//   plus carry (CY) and zero (Z) flags, drives registered ALU operands, samples
//   the ALU result after ALU_LATENCY cycles, writes back A and the flags, and
//   returns a response over a second valid/ready pair.
//
// Parameters
//   ALU_LATENCY   cycles from ALU port drive to result sample (1..7)
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_wr                     1 = register load, 0 = ALU op
//   cmd_op[3:0]                ALU operation code
//   cmd_src[2:0]               operand_b source register (load: destination)
//   cmd_use_imm, cmd_imm[7:0]  immediate select / immediate or load data
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_carry,       A after the op (load: loaded value), CY, Z
//   rsp_zero, rsp_err          rsp_err = divide-by-zero reject
//   alu_a, alu_b, alu_op       registered drive to the ALU
//   alu_result, alu_carry      ALU outputs
//
// Optional feature: define ALU_SEQ_OPCOUNT_EN to add op_count[15:0] (completed
// ALU ops, compares included) and err_count[7:0] (divide-by-zero rejects).
// Both saturate at all-ones; loads are not counted.
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | ALU operands driven, waiting out ALU_LATENCY
// RESP  | response held until the consumer takes it
module alu_op_sequencer #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [3:0] cmd_op,
  input  logic [2:0] cmd_src,
  input  logic       cmd_use_imm,
  input  logic [7:0] cmd_imm,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_carry
`ifdef ALU_SEQ_OPCOUNT_EN
  ,
  output logic [15:0] op_count,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0011;

  state_t          state, state_nxt;
  logic [7:0][7:0] regs;
  logic            flag_cy, flag_z;
  logic [2:0]      wait_cnt;

  logic       accept;
  logic [7:0] opnd_b;
  logic       div0;
  logic       wait_tc;
  logic       wb_cmp;
  logic [7:0] wb_a;
  logic       wb_z;
  logic       wb_cy;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid & cmd_ready;
  assign opnd_b    = cmd_use_imm ? cmd_imm : regs[cmd_src];
  assign div0      = !cmd_wr && (cmd_op == OP_DIV) && (opnd_b == 8'h00);
  // Counter is loaded with ALU_LATENCY; the result is sampled on the edge
  // that takes it from 1 to 0.
  assign wait_tc   = (state == ISSUE) && (wait_cnt == 3'd1);

  // Writeback values; compares (111x) only update Z.
  always_comb begin
    wb_cmp = (alu_op[3:1] == 3'b111);
    wb_a   = wb_cmp ? regs[0] : alu_result;
    wb_z   = (alu_result == 8'h00);
    wb_cy  = flag_cy;
    if (alu_op == OP_ADD) begin
      wb_cy = alu_carry;
    end else if (alu_op == OP_SUB) begin
      wb_cy = (alu_a < alu_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (cmd_wr || div0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (wait_tc) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs      <= '0;
      flag_cy   <= 1'b0;
      flag_z    <= 1'b0;
      wait_cnt  <= 3'd0;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_op    <= 4'h0;
      rsp_data  <= 8'h00;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        rsp_err <= 1'b0;
        if (cmd_wr) begin
          regs[cmd_src] <= cmd_imm;
          rsp_data      <= cmd_imm;
          rsp_carry     <= flag_cy;
          rsp_zero      <= flag_z;
        end else if (div0) begin
          // ALU is not issued; its ports keep their previous values.
          rsp_err   <= 1'b1;
          rsp_data  <= regs[0];
          rsp_carry <= flag_cy;
          rsp_zero  <= flag_z;
        end else begin
          alu_a    <= regs[0];
          alu_b    <= opnd_b;
          alu_op   <= cmd_op;
          wait_cnt <= 3'(ALU_LATENCY);
        end
      end
      if (state == ISSUE) begin
        wait_cnt <= wait_cnt - 3'd1;
        if (wait_tc) begin
          regs[0]   <= wb_a;
          flag_z    <= wb_z;
          flag_cy   <= wb_cy;
          rsp_data  <= wb_a;
          rsp_zero  <= wb_z;
          rsp_carry <= wb_cy;
        end
      end
    end
  end

`ifdef ALU_SEQ_OPCOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= 16'h0000;
      err_count <= 8'h00;
    end else begin
      if (wait_tc && (op_count != 16'hFFFF)) begin
        op_count <= op_count + 16'h0001;
      end
      if (accept && div0 && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'h01;
      end
    end
  end
`endif

endmodule
